// File: rtl/uart_rx_os_if.sv
// Received-byte handshake between the UART receiver and its consumer.
interface uart_rx_os_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data_o;
   logic                 valid_o;
   logic                 ready_i;
   logic                 frm_err_o;

   modport master (output data_o, output valid_o, output frm_err_o, input ready_i);
   modport slave  (input data_o, input valid_o, input frm_err_o, output ready_i);
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 3-sample majority vote at each bit centre,
// bytes delivered over valid/ready with framing and sticky overrun flags.
module uart_rx_os #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         brg_stb_i,
   input  logic         rx_i,
   uart_rx_os_if.master out_if,
   output logic         ovr_err_o,
   output logic         busy_o
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] T_LO   = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_HI   = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [TW-1:0]          t_q, t_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [1:0]             smp_q, smp_d;
   logic [DATA_BITS-1:0]   sh_q, sh_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   frm_q, frm_d;
   logic                   ovr_q, ovr_d;
   logic                   busy_q, busy_d;
   logic                   rx_s, vote, done;

   assign rx_s = sync_q[SYNC_STAGES-1];
   // The third sample is the live synced value on the vote tick itself.
   assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], rx_i};
      state_d = state_q;
      t_d     = t_q;
      bit_d   = bit_q;
      smp_d   = smp_q;
      sh_d    = sh_q;
      data_d  = data_q;
      valid_d = valid_q;
      frm_d   = frm_q;
      ovr_d   = ovr_q;
      done    = 1'b0;

      if (brg_stb_i) begin
         case (state_q)
            S_IDLE: begin
               if (!rx_s) begin
                  state_d = S_START;
                  t_d     = TW'(1);
               end
            end
            S_START, S_DATA, S_STOP: begin
               t_d = (t_q == T_LAST) ? '0 : t_q + 1'b1;
               if (t_q == T_LO)  smp_d[0] = rx_s;
               if (t_q == T_MID) smp_d[1] = rx_s;
               if (state_q == S_START) begin
                  if (t_q == T_HI && vote) begin
                     state_d = S_IDLE;
                  end else if (t_q == T_LAST) begin
                     state_d = S_DATA;
                     bit_d   = '0;
                  end
               end else if (state_q == S_DATA) begin
                  if (t_q == T_HI) sh_d = {vote, sh_q[DATA_BITS-1:1]};
                  if (t_q == T_LAST) begin
                     if (bit_q == B_LAST) state_d = S_STOP;
                     else                 bit_d   = bit_q + 1'b1;
                  end
               end else if (t_q == T_HI) begin
                  // Frame ends at the stop vote so an early next start is not missed.
                  done    = 1'b1;
                  state_d = vote ? S_IDLE : S_BREAK;
               end
            end
            S_BREAK: begin
               if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (done) begin
         if (!valid_q || out_if.ready_i) begin
            data_d  = sh_q;
            frm_d   = ~vote;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && out_if.ready_i) begin
         valid_d = 1'b0;
      end

      if (clr_i) begin
         state_d = S_IDLE;
         t_d     = '0;
         bit_d   = '0;
         smp_d   = '0;
         sh_d    = '0;
         data_d  = '0;
         valid_d = 1'b0;
         frm_d   = 1'b0;
         ovr_d   = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= '1;
         state_q <= S_IDLE;
         t_q     <= '0;
         bit_q   <= '0;
         smp_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         frm_q   <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         t_q     <= t_d;
         bit_q   <= bit_d;
         smp_q   <= smp_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         frm_q   <= frm_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
      end
   end

   assign out_if.data_o    = data_q;
   assign out_if.valid_o   = valid_q;
   assign out_if.frm_err_o = frm_q;
   assign ovr_err_o        = ovr_q;
   assign busy_o           = busy_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed and randomized frames against a majority-vote reference model and an acceptance scoreboard.
module tb_uart_rx_os;
   localparam int DB = 8;
   localparam int OS = 16;

   logic clk = 1'b0;
   logic rst_i, clr_i, brg_stb_i, rx_i, ovr_err_o, busy_o;
   int   errors = 0;
   int   checks = 0;
   int   stb_cnt = 0;
   logic [DB:0] acc_q[$];

   uart_rx_os_if #(.DATA_BITS(DB)) bus ();

   uart_rx_os #(.DATA_BITS(DB), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .brg_stb_i(brg_stb_i),
      .rx_i(rx_i), .out_if(bus), .ovr_err_o(ovr_err_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // Strobe changes on the falling edge: one tick every 4 clocks.
   initial begin
      brg_stb_i = 1'b0;
      forever begin
         @(negedge clk);
         brg_stb_i = (stb_cnt % 4 == 3);
         stb_cnt++;
      end
   end

   always @(posedge clk)
      if (!rst_i && bus.valid_o && bus.ready_i) acc_q.push_back({bus.frm_err_o, bus.data_o});

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   // Drive rx, return 1 time unit after the next tick edge (which sees the new value).
   task automatic tick(input logic v);
      rx_i = v;
      @(posedge clk);
      while (brg_stb_i !== 1'b1) @(posedge clk);
      #1;
   endtask

   // Sends start + data (with per-bit centre-sample flips) + stop, returning right after the stop vote tick.
   task automatic send_frame(input logic [DB-1:0] dat, input logic stop_v,
                             input logic [3*DB-1:0] flips, input bit rdy_at_done);
      for (int t = 0; t < OS; t++) tick(1'b0);
      for (int b = 0; b < DB; b++) begin
         for (int t = 0; t < OS; t++) begin
            logic f;
            f = (t >= 7 && t <= 9) ? flips[3*b + t - 7] : 1'b0;
            tick(dat[b] ^ f);
         end
      end
      for (int t = 0; t < 9; t++) tick(stop_v);
      if (rdy_at_done) begin
         repeat (3) clk1();
         bus.ready_i = 1'b1;
      end
      tick(stop_v);
      if (rdy_at_done) bus.ready_i = 1'b0;
   endtask

   // Each data bit is the majority of its three centre samples.
   function automatic logic [DB-1:0] model_byte(input logic [DB-1:0] dat, input logic [3*DB-1:0] flips);
      logic [DB-1:0] r;
      for (int b = 0; b < DB; b++) begin
         int ones;
         ones = 0;
         for (int k = 0; k < 3; k++) ones += (dat[b] ^ flips[3*b + k]) ? 1 : 0;
         r[b] = (ones >= 2);
      end
      return r;
   endfunction

   task automatic expect_acc(input string tag, input logic [DB-1:0] d, input logic fe);
      check({tag, "_cnt"}, 32'(acc_q.size()), 1);
      if (acc_q.size() != 0) begin
         logic [DB:0] e;
         e = acc_q.pop_front();
         check(tag, 32'(e), 32'({fe, d}));
      end
   endtask

   initial begin
      rst_i = 1'b1; clr_i = 1'b0; rx_i = 1'b1; bus.ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", 32'(bus.data_o), 0);
      check("rst_valid", 32'(bus.valid_o), 0);
      check("rst_frm", 32'(bus.frm_err_o), 0);
      check("rst_ovr", 32'(ovr_err_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      rst_i = 1'b0;
      repeat (4) tick(1'b1);

      // Basic frame
      bus.ready_i = 1'b1;
      send_frame(8'h55, 1'b1, '0, 1'b0);
      check("f55_valid", 32'(bus.valid_o), 1);
      check("f55_data", 32'(bus.data_o), 32'h55);
      check("f55_frm", 32'(bus.frm_err_o), 0);
      check("f55_ovr", 32'(ovr_err_o), 0);
      check("f55_busy", 32'(busy_o), 0);
      clk1();
      check("f55_valid_drop", 32'(bus.valid_o), 0);
      expect_acc("f55_acc", 8'h55, 1'b0);
      repeat (6) tick(1'b1);

      // False start: low for ticks 0..2 only
      repeat (3) tick(1'b0);
      repeat (6) tick(1'b1);
      check("fs_busy_t8", 32'(busy_o), 1);
      tick(1'b1);
      check("fs_busy_t9", 32'(busy_o), 0);
      repeat (8) tick(1'b1);
      check("fs_no_frame", 32'(acc_q.size()), 0);
      check("fs_valid", 32'(bus.valid_o), 0);

      // One-tick glitch at t=8 of data bit 3
      send_frame(8'hA5, 1'b1, 24'h000400, 1'b0);
      clk1();
      expect_acc("glitch", 8'hA5, 1'b0);
      repeat (6) tick(1'b1);

      // Line held low for 20 bit times
      repeat (20 * OS) tick(1'b0);
      expect_acc("brk", 8'h00, 1'b1);
      check("brk_busy", 32'(busy_o), 1);
      repeat (16) tick(1'b1);
      check("brk_idle", 32'(busy_o), 0);
      check("brk_no_more", 32'(acc_q.size()), 0);
      send_frame(8'h3C, 1'b1, '0, 1'b0);
      clk1();
      expect_acc("after_brk", 8'h3C, 1'b0);
      repeat (6) tick(1'b1);

      // Overrun
      bus.ready_i = 1'b0;
      send_frame(8'h11, 1'b1, '0, 1'b0);
      repeat (6) tick(1'b1);
      send_frame(8'h22, 1'b1, '0, 1'b0);
      check("ovr_valid", 32'(bus.valid_o), 1);
      check("ovr_data", 32'(bus.data_o), 32'h11);
      check("ovr_flag", 32'(ovr_err_o), 1);
      repeat (6) tick(1'b1);
      bus.ready_i = 1'b1;
      clk1();
      bus.ready_i = 1'b0;
      check("ovr_pop_valid", 32'(bus.valid_o), 0);
      check("ovr_sticky", 32'(ovr_err_o), 1);
      expect_acc("ovr_pop", 8'h11, 1'b0);
      clr_i = 1'b1;
      clk1();
      clr_i = 1'b0;
      check("clr_ovr", 32'(ovr_err_o), 0);
      repeat (4) tick(1'b1);

      // Reset during data bit 4, with a held byte pending
      send_frame(8'hF0, 1'b1, '0, 1'b0);
      repeat (6) tick(1'b1);
      repeat (5 * OS + 8) tick(1'b0);
      check("pre_rst_busy", 32'(busy_o), 1);
      #2 rst_i = 1'b1;
      #1;
      check("mid_rst_data", 32'(bus.data_o), 0);
      check("mid_rst_valid", 32'(bus.valid_o), 0);
      check("mid_rst_busy", 32'(busy_o), 0);
      check("mid_rst_frm", 32'(bus.frm_err_o), 0);
      check("mid_rst_ovr", 32'(ovr_err_o), 0);
      clk1();
      rx_i = 1'b1;
      clk1();
      rst_i = 1'b0;
      repeat (4) tick(1'b1);
      bus.ready_i = 1'b1;
      send_frame(8'h81, 1'b1, '0, 1'b0);
      check("post_rst_data", 32'(bus.data_o), 32'h81);
      clk1();
      expect_acc("post_rst", 8'h81, 1'b0);
      repeat (6) tick(1'b1);

      // Consumer accepts on the very clock a new frame completes
      bus.ready_i = 1'b0;
      send_frame(8'h5A, 1'b1, '0, 1'b0);
      repeat (6) tick(1'b1);
      send_frame(8'hC3, 1'b1, '0, 1'b1);
      check("same_valid", 32'(bus.valid_o), 1);
      check("same_data", 32'(bus.data_o), 32'hC3);
      check("same_ovr", 32'(ovr_err_o), 0);
      expect_acc("same_old", 8'h5A, 1'b0);
      bus.ready_i = 1'b1;
      clk1();
      expect_acc("same_new", 8'hC3, 1'b0);
      repeat (6) tick(1'b1);

      // Randomized frames with centre-sample noise and occasional bad stop bits
      for (int n = 0; n < 8; n++) begin
         logic [DB-1:0]   d;
         logic [3*DB-1:0] fl;
         logic            st;
         d  = DB'($urandom);
         fl = (3*DB)'($urandom & $urandom);
         st = ($urandom_range(0, 3) != 0);
         send_frame(d, st, fl, 1'b0);
         clk1();
         expect_acc("rnd", model_byte(d, fl), ~st);
         if (st) begin
            repeat (6) tick(1'b1);
         end else begin
            repeat (6) tick(1'b0);
            repeat (4) tick(1'b1);
         end
      end
      check("rnd_ovr", 32'(ovr_err_o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver.
- Consumes the oversample strobe produced by the fractional baud rate generator and recovers 8N1-style frames from an asynchronous serial line.
- Each bit is decided by a 3-sample majority vote at the bit centre.
- Received bytes go out through a valid/ready handshake, with framing and overrun error flags.
- Sits between the board's RX pin and the boot-loader byte consumer.

Parameters:
- DATA_BITS, 8: data bits per frame, LSB first; range 5..9.
- OVERSAMPLE, 16: strobe ticks per bit; must match the generator's OVERSAMPLE; even and >= 8.
- SYNC_STAGES, 2: rx_i synchronizer depth; >= 2.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- clr_i  in  1  synchronous clear, also the receiver enable gate
- brg_stb_i  in  1  oversample tick; single-clk_i pulse from the baud rate generator
- rx_i  in  1  asynchronous serial input; idle high
- data_o  out  DATA_BITS  received data
- valid_o  out  1  data_o/frm_err_o valid
- ready_i  in  1  consumer accepts data when valid_o & ready_i at a clk_i edge
- frm_err_o  out  1  stop bit sampled 0 for the frame in data_o
- ovr_err_o  out  1  sticky: a frame was dropped because the output register was full
- busy_o  out  1  frame reception in progress

Behaviour:
- Reset (rst_i):
  - Synchronizer flops reset to 1.
  - data_o=0, valid_o=0, frm_err_o=0, ovr_err_o=0, busy_o=0; state IDLE.
  - A reset mid-frame abandons the frame immediately.
- clr_i: same effect as reset on every register except the synchronizer; takes priority over all other events.
- Timing: all state and counter advances occur only on clk_i edges where brg_stb_i=1 ("tick"). The handshake is evaluated every clk_i.
- Counters:
  - tick counter t, width clog2(OVERSAMPLE), wraps OVERSAMPLE-1 -> 0.
  - bit index, counts 0..DATA_BITS-1.
- Voting:
  - M = OVERSAMPLE/2.
  - Within each bit, samples are taken at t = M-1, M, M+1.
  - At t = M+1, vote = majority(3 samples).
- IDLE:
  - On a tick with synced rx=0: go to START with t=1. The detect tick is tick 0.
  - busy_o=0 only in IDLE.
- START:
  - Vote = 1: false start, go to IDLE at that tick.
  - Vote = 0: continue. At t = OVERSAMPLE-1 go to DATA with bit index 0 and t=0.
- DATA:
  - Vote shifts into the shift register, LSB first.
  - After bit DATA_BITS-1 completes its wrap, go to STOP.
- STOP:
  - At t = M+1 (vote tick), the frame completes. The remainder of the stop bit is not waited for, so the next start edge can be detected early.
  - Vote = 1: go to IDLE.
  - Vote = 0: go to BREAK.
- BREAK: wait until a tick with synced rx=1, then go to IDLE. No new start is detected while rx stays low.
- Frame delivery (on the completion clk):
  - valid_o=0, or valid_o=1 & ready_i=1 in the same cycle: load data_o, set frm_err_o=~vote, valid_o=1 from the next clk. No overrun.
  - valid_o=1 & ready_i=0: new frame discarded, data_o/frm_err_o unchanged, ovr_err_o<=1.
- Overrun flag: ovr_err_o clears only by rst_i or clr_i.
- Handshake:
  - valid_o & ready_i with no frame completing: valid_o<=0 next clk.
  - data_o holds while valid_o=1.
- Latency: valid_o rises 1 clk_i after the STOP vote tick.
- busy_o: 1 in START/DATA/STOP/BREAK.

Test Plan:
Common setup: OVERSAMPLE=16, brg_stb_i every 4 clks, bit = 64 clks.
- Frame 0x55 (start 0, stop 1), ready_i=1 -> valid_o pulses 1 clk after stop tick 9; data_o=0x55, frm_err_o=0, ovr_err_o=0; busy_o falls same edge.
- rx_i low for ticks 0..2 only -> false start at tick 9; no valid_o; busy_o back to 0 by tick 9.
- Frame 0xA5 with rx inverted for exactly one tick at t=8 of bit 3 -> data_o=0xA5, frm_err_o=0.
- rx_i held low for 20 bit times, then frame 0x3C -> one delivery data_o=0x00 with frm_err_o=1; no further frames during the low period; then data_o=0x3C with frm_err_o=0.
- Frames 0x11, 0x22 back-to-back with ready_i=0 -> data_o=0x11 and ovr_err_o=1 after the second frame. ready_i pulse -> valid_o=0, ovr_err_o stays 1. clr_i -> ovr_err_o=0.
- Reset and handshake corners:
  - rst_i pulsed during DATA bit 4 -> all outputs 0 immediately; next frame 0x81 received correctly.
  - ready_i=1 on the same clk a frame completes -> new data loaded, valid_o stays 1, no overrun.
